// File: rtl/fb_wr_sched.sv
// Frame-synchronous write-port scheduler for the camera frame buffer (port A).
// Optional stall counter output enabled by defining FB_WR_SCHED_STALL_CNT_EN.
module fb_wr_sched #(
  parameter int c_nb_img_pxls = 15,
  parameter int c_img_pxls    = 19200,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_frame_start,
  input  logic                     cap_we,
  input  logic [c_nb_img_pxls-1:0] cap_addr,
  input  logic [c_nb_buf-1:0]      cap_data,
  input  logic                     proc_req,
  input  logic [c_nb_img_pxls-1:0] proc_addr,
  input  logic [c_nb_buf-1:0]      proc_data,
  output logic                     proc_gnt,
  input  logic                     cmd_live,
  input  logic                     cmd_freeze,
  input  logic                     cmd_snap,
  output logic                     fb_we,
  output logic [c_nb_img_pxls-1:0] fb_addr,
  output logic [c_nb_buf-1:0]      fb_din,
  output logic [2:0]               mode,
  output logic [7:0]               frame_cnt,
  output logic                     addr_err
`ifdef FB_WR_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic [2:0] {
    LIVE      = 3'd0,
    FRZ_PEND  = 3'd1,
    FROZEN    = 3'd2,
    SNAP_WAIT = 3'd3,
    SNAP_CAP  = 3'd4,
    LIVE_PEND = 3'd5
  } state_t;

  localparam logic [c_nb_img_pxls:0] c_lim = (c_nb_img_pxls + 1)'(c_img_pxls);

  state_t                   state_reg;
  logic                     fb_we_reg;
  logic [c_nb_img_pxls-1:0] fb_addr_reg;
  logic [c_nb_buf-1:0]      fb_din_reg;
  logic [7:0]               frame_cnt_reg;
  logic                     addr_err_reg;

  logic                     cap_en;
  logic                     cap_wr;
  logic                     win_valid;
  logic [c_nb_img_pxls-1:0] win_addr;
  logic [c_nb_buf-1:0]      win_data;
  logic                     addr_ok;
  logic                     sel_snap;
  logic                     sel_freeze;

  assign cap_en = (state_reg == LIVE) || (state_reg == FRZ_PEND) || (state_reg == SNAP_CAP);
  assign cap_wr = cap_we & cap_en;

  // Grant is forced low during reset so the engine never sees a phantom accept.
  assign proc_gnt  = rst_n & proc_req & ~cap_wr;
  assign win_valid = cap_wr | proc_gnt;
  assign win_addr  = cap_wr ? cap_addr : proc_addr;
  assign win_data  = cap_wr ? cap_data : proc_data;
  assign addr_ok   = {1'b0, win_addr} < c_lim;

  // Only the highest-priority command is considered each cycle.
  assign sel_snap   = cmd_snap & ~cmd_live;
  assign sel_freeze = cmd_freeze & ~cmd_live & ~cmd_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LIVE;
      fb_we_reg     <= 1'b0;
      fb_addr_reg   <= '0;
      fb_din_reg    <= '0;
      frame_cnt_reg <= 8'd0;
      addr_err_reg  <= 1'b0;
    end else begin
      fb_we_reg <= win_valid & addr_ok;
      if (win_valid & addr_ok) begin
        fb_addr_reg <= win_addr;
        fb_din_reg  <= win_data;
      end
      if (win_valid & ~addr_ok)
        addr_err_reg <= 1'b1;
      if (cap_frame_start & cap_en)
        frame_cnt_reg <= frame_cnt_reg + 8'd1;

      // A command that changes state masks a coincident frame start.
      case (state_reg)
        LIVE:      if (sel_freeze)           state_reg <= FRZ_PEND;
        FRZ_PEND:  if (cmd_live)             state_reg <= LIVE;
                   else if (cap_frame_start) state_reg <= FROZEN;
        FROZEN:    if (cmd_live)             state_reg <= LIVE_PEND;
                   else if (sel_snap)        state_reg <= SNAP_WAIT;
        SNAP_WAIT: if (cmd_live)             state_reg <= LIVE_PEND;
                   else if (cap_frame_start) state_reg <= SNAP_CAP;
        SNAP_CAP:  if (cmd_live)             state_reg <= LIVE;
                   else if (cap_frame_start) state_reg <= FROZEN;
        LIVE_PEND: if (sel_freeze)           state_reg <= FROZEN;
                   else if (cap_frame_start) state_reg <= LIVE;
        default:                             state_reg <= LIVE;
      endcase
    end
  end

  assign fb_we     = fb_we_reg;
  assign fb_addr   = fb_addr_reg;
  assign fb_din    = fb_din_reg;
  assign mode      = state_reg;
  assign frame_cnt = frame_cnt_reg;
  assign addr_err  = addr_err_reg;

`ifdef FB_WR_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= 16'd0;
    else if (cmd_live)
      stall_cnt_reg <= 16'd0;
    else if (proc_req & ~proc_gnt & (stall_cnt_reg != 16'hFFFF))
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fb_wr_sched.sv
// Directed testbench for fb_wr_sched: capture/processing arbitration, mode FSM, frame counting.
// Define FB_WR_SCHED_STALL_CNT_EN to also exercise the stall counter.
module tb_fb_wr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_frame_start, cap_we, proc_req, cmd_live, cmd_freeze, cmd_snap;
  logic [14:0] cap_addr, proc_addr;
  logic [11:0] cap_data, proc_data;
  logic        proc_gnt, fb_we, addr_err;
  logic [14:0] fb_addr;
  logic [11:0] fb_din;
  logic [2:0]  mode;
  logic [7:0]  frame_cnt;
`ifdef FB_WR_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int we_cnt;

  fb_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .cap_frame_start(cap_frame_start),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_data(proc_data),
    .proc_gnt(proc_gnt), .cmd_live(cmd_live), .cmd_freeze(cmd_freeze),
    .cmd_snap(cmd_snap), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .mode(mode), .frame_cnt(frame_cnt), .addr_err(addr_err)
`ifdef FB_WR_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %-14s got %0h", tag, act);
    end else
      $display("FAIL %-14s got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {cap_frame_start, cap_we, proc_req, cmd_live, cmd_freeze, cmd_snap} = '0;
    cap_addr = '0; cap_data = '0; proc_addr = '0; proc_data = '0;
    proc_req = 1'b1;
    tick(); tick();
    chk("rst_gnt", proc_gnt, 0);
    proc_req = 1'b0;
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_din", fb_din, 0);
    chk("rst_mode", mode, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_err", addr_err, 0);
    rst_n = 1'b1;
    tick();

    // Basic capture write, one cycle latency
    cap_we = 1; cap_addr = 15'h0005; cap_data = 12'hABC;
    tick();
    cap_we = 0;
    chk("cap_we", fb_we, 1);
    chk("cap_addr", fb_addr, 15'h0005);
    chk("cap_din", fb_din, 12'hABC);
    chk("cap_mode", mode, 0);
    tick();
    chk("cap_idle", fb_we, 0);

    // Capture beats processing, then processing gets its slot
    cap_we = 1; cap_addr = 15'd10; cap_data = 12'h111;
    proc_req = 1; proc_addr = 15'd20; proc_data = 12'h222;
    #1 chk("arb_nogr", proc_gnt, 0);
    tick();
    chk("arb_capwe", fb_we, 1);
    chk("arb_capadr", fb_addr, 15'd10);
    chk("arb_capdin", fb_din, 12'h111);
    cap_we = 0;
    #1 chk("arb_gnt", proc_gnt, 1);
    tick();
    proc_req = 0;
    chk("arb_prwe", fb_we, 1);
    chk("arb_pradr", fb_addr, 15'd20);
    chk("arb_prdin", fb_din, 12'h222);

    // Freeze at frame boundary
    cmd_freeze = 1; tick(); cmd_freeze = 0;
    chk("frz_pend", mode, 1);
    cap_frame_start = 1; tick(); cap_frame_start = 0;
    chk("frz_mode", mode, 2);
    chk("frz_fcnt", frame_cnt, 1);
    cap_we = 1; cap_addr = 15'd7; cap_data = 12'h777;
    tick();
    chk("frz_nowe", fb_we, 0);
    proc_req = 1; proc_addr = 15'd30; proc_data = 12'h333;
    #1 chk("frz_gnt", proc_gnt, 1);
    tick();
    chk("frz_prwe", fb_we, 1);
    chk("frz_pradr", fb_addr, 15'd30);
    #1 chk("frz_gnt2", proc_gnt, 1);
    tick();
    cap_we = 0; proc_req = 0;

    // Single snapshot: exactly three writes land
    cmd_snap = 1; tick(); cmd_snap = 0;
    chk("snp_wait", mode, 3);
    cap_frame_start = 1; tick(); cap_frame_start = 0;
    chk("snp_cap", mode, 4);
    chk("snp_fcnt0", frame_cnt, 1);
    we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cap_we = 1; cap_addr = 15'(100 + i); cap_data = 12'(i + 1);
      tick();
      we_cnt += int'(fb_we);
    end
    cap_we = 0; cap_frame_start = 1;
    tick();
    cap_frame_start = 0;
    we_cnt += int'(fb_we);
    chk("snp_last", fb_addr, 15'd102);
    chk("snp_mode", mode, 2);
    chk("snp_fcnt", frame_cnt, 2);
    cap_we = 1; tick(); cap_we = 0;
    we_cnt += int'(fb_we);
    chk("snp_wecnt", we_cnt, 3);

    // Return to live via LIVE_PEND, then address range check
    cmd_live = 1; tick(); cmd_live = 0;
    chk("lp_mode", mode, 5);
    cap_frame_start = 1; tick(); cap_frame_start = 0;
    chk("lp_live", mode, 0);
    chk("lp_fcnt", frame_cnt, 2);
    cap_we = 1; cap_addr = 15'd19200; cap_data = 12'hFFF;
    tick();
    chk("oor_nowe", fb_we, 0);
    chk("oor_err", addr_err, 1);
    cap_addr = 15'd19199; cap_data = 12'h0F0;
    tick();
    cap_we = 0;
    chk("edge_we", fb_we, 1);
    chk("edge_adr", fb_addr, 15'd19199);
    chk("err_stky", addr_err, 1);
    proc_req = 1; proc_addr = 15'd20000;
    #1 chk("oorp_gnt", proc_gnt, 1);
    tick();
    proc_req = 0;
    chk("oorp_nowe", fb_we, 0);

    // Command priority and command-vs-frame-start ordering
    cmd_freeze = 1; tick(); cmd_freeze = 0;
    chk("pri_pend", mode, 1);
    cmd_live = 1; cmd_freeze = 1; tick(); cmd_live = 0; cmd_freeze = 0;
    chk("pri_live", mode, 0);
    cap_frame_start = 1; tick(); cap_frame_start = 0;
    chk("live_fcnt", frame_cnt, 3);
    cmd_freeze = 1; tick(); cmd_freeze = 0;
    cap_frame_start = 1; tick(); cap_frame_start = 0;
    chk("frz2_mode", mode, 2);
    chk("frz2_fcnt", frame_cnt, 4);
    cmd_snap = 1; cap_frame_start = 1; tick(); cmd_snap = 0; cap_frame_start = 0;
    chk("cmdfs_mode", mode, 3);
    chk("cmdfs_fcnt", frame_cnt, 4);

    // Back to live; stall counter if present
    cmd_live = 1; tick(); cmd_live = 0;
    chk("sw_lp", mode, 5);
`ifdef FB_WR_SCHED_STALL_CNT_EN
    chk("stl_clr0", stall_cnt, 0);
`endif
    cap_frame_start = 1; tick(); cap_frame_start = 0;
    chk("sw_live", mode, 0);
    proc_req = 1; proc_addr = 15'd55; proc_data = 12'h555;
    for (int i = 0; i < 10; i++) begin
      cap_we = 1; cap_addr = 15'(200 + i); cap_data = 12'h0AA;
      tick();
    end
    cap_we = 0;
    #1 chk("stl_gnt", proc_gnt, 1);
`ifdef FB_WR_SCHED_STALL_CNT_EN
    chk("stl_cnt", stall_cnt, 10);
`endif
    tick();
    proc_req = 0;
    chk("stl_prwe", fb_addr, 15'd55);
`ifdef FB_WR_SCHED_STALL_CNT_EN
    chk("stl_hold", stall_cnt, 10);
    cmd_live = 1; tick(); cmd_live = 0;
    chk("stl_clr", stall_cnt, 0);
`endif

    // Asynchronous reset mid-write
    cmd_freeze = 1; tick(); cmd_freeze = 0;
    cap_we = 1; cap_addr = 15'd3; cap_data = 12'h333; proc_req = 1;
    tick();
    chk("ar_pre_we", fb_we, 1);
    #3 rst_n = 0;
    #1;
    chk("ar_we", fb_we, 0);
    chk("ar_mode", mode, 0);
    chk("ar_fcnt", frame_cnt, 0);
    chk("ar_err", addr_err, 0);
    chk("ar_gnt", proc_gnt, 0);
    cap_we = 0; proc_req = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_wr_sched.md
Name: fb_wr_sched

Overview:
- Frame-synchronous write-port scheduler for the camera frame buffer (port A).
- Arbitrates between two sources: the camera capture stream, which cannot be stalled, and a pixel-processing/overlay engine, which uses a req/gnt handshake.
- Implements live, freeze and single-snapshot modes, switching only on frame boundaries to avoid tearing.
- Sits between the capture unit, the processing engine and the frame buffer; runs in the 50 MHz system domain.

Parameters:
- c_nb_img_pxls, 15, address width of the frame buffer.
- c_img_pxls, 19200, number of valid pixel addresses (0..c_img_pxls-1).
- c_nb_buf, 12, pixel word width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- cap_frame_start  in  1  one-cycle pulse at camera frame start (vsync edge, already in clk domain).
- cap_we  in  1  capture pixel write strobe.
- cap_addr  in  c_nb_img_pxls  capture write address.
- cap_data  in  c_nb_buf  capture pixel.
- proc_req  in  1  processing write request; addr/data are held stable until granted.
- proc_addr  in  c_nb_img_pxls  processing write address.
- proc_data  in  c_nb_buf  processing pixel.
- proc_gnt  out  1  processing request accepted this cycle.
- cmd_live  in  1  one-cycle command: resume live capture.
- cmd_freeze  in  1  one-cycle command: freeze at the next frame boundary.
- cmd_snap  in  1  one-cycle command: capture exactly one frame, then freeze.
- fb_we  out  1  frame buffer write enable.
- fb_addr  out  c_nb_img_pxls  frame buffer address.
- fb_din  out  c_nb_buf  frame buffer data.
- mode  out  3  current state encoding (used for LEDs).
- frame_cnt  out  8  frames written to the buffer, wraps.
- addr_err  out  1  sticky: an out-of-range write was dropped.

Behaviour:
- Reset: state LIVE(0); fb_we=0, fb_addr=0, fb_din=0, frame_cnt=0, addr_err=0, proc_gnt=0.
- Reset asserted mid-operation aborts everything immediately.
- cap_en is decoded from the registered state: 1 in LIVE, FRZ_PEND and SNAP_CAP; 0 otherwise.
- Capture path:
  - An effective capture write is cap_we & cap_en.
  - Capture has absolute priority.
  - fb_we/addr/din are registered: 1-cycle latency from cap_we to fb_we.
- Processing path:
  - proc_gnt = proc_req & ~(cap_we & cap_en). This is combinational, and proc_gnt must be 0 while rst_n=0.
  - A grant produces fb_we on the next cycle with proc_addr/proc_data.
  - An ungranted request waits; there is no timeout and starvation is bounded by capture idle gaps.
- Address check:
  - A winning write with address >= c_img_pxls is dropped: fb_we stays 0 that cycle and addr_err is set.
  - The processing request is still granted, so it completes.
- Commands are evaluated once per cycle. If more than one is asserted in the same cycle, priority is cmd_live > cmd_snap > cmd_freeze.
- States (encoding), transitions and commands not listed are ignored:
  - LIVE(0): cmd_freeze -> FRZ_PEND.
  - FRZ_PEND(1): cap_frame_start -> FROZEN; cmd_live -> LIVE.
  - FROZEN(2): cmd_snap -> SNAP_WAIT; cmd_live -> LIVE_PEND.
  - SNAP_WAIT(3): cap_frame_start -> SNAP_CAP; cmd_live -> LIVE_PEND.
  - SNAP_CAP(4): cap_frame_start -> FROZEN; cmd_live -> LIVE; cmd_freeze ignored.
  - LIVE_PEND(5): cap_frame_start -> LIVE; cmd_freeze -> FROZEN.
- A command and cap_frame_start in the same cycle: the command is applied first, and the resulting state ignores that frame_start.
  - Example: FROZEN + cmd_snap + frame_start -> SNAP_WAIT, which waits for the next frame.
- frame_cnt increments (mod 256) on cap_frame_start when the current state has cap_en=1. The frame just ended was being written.
- mode outputs the state encoding.

Optional Feature:
- Macro: FB_WR_SCHED_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[15:0], which increments (saturating at 0xFFFF) on each cycle with proc_req=1 and proc_gnt=0.
  - stall_cnt clears on reset and on cmd_live.
- When undefined: the port and counter are absent; other behaviour is identical.

Test Plan:
- Reset, then cap_we pulses to addr 0x0005, data 0xABC -> fb_we=1 one cycle later, fb_addr=0x0005, fb_din=0xABC; mode=0.
- cap_we=1 and proc_req=1 in the same cycle -> proc_gnt=0, capture written. Next cycle cap_we=0 -> proc_gnt=1, and proc data appears on fb_din one cycle later.
- cmd_freeze, then cap_frame_start -> mode 1, then 2. Later cap_we produces no fb_we; frame_cnt increments by 1; proc_req granted every cycle.
- In FROZEN: cmd_snap, frame_start, 3 cap_we, frame_start -> mode 3 -> 4 -> 2; exactly 3 fb_we; frame_cnt +1.
- cap_addr=19200 in LIVE -> no fb_we, addr_err=1 and it stays set; cmd_live+cmd_freeze in the same cycle in FRZ_PEND -> LIVE.
- With FB_WR_SCHED_STALL_CNT_EN: hold proc_req under 10 consecutive capture writes -> stall_cnt=10; cmd_live -> 0.
